universal_shift_reg: RTL and testbench

Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register that holds, loads, shifts, rotates or clears under a mode code. It also has a shift counter that flags when a full word has been serialised since the last load. It is the standard storage/serialiser primitive for the team's later serial-interface and counter projects. All outputs are registered.

---
 rtl/usr_pkg.sv | 17 +
 rtl/universal_shift_reg_if.sv | 18 +
 rtl/usr_shift_counter.sv | 47 ++++
 rtl/universal_shift_reg.sv | 52 +++++
 tb/tb_universal_shift_reg.sv | 128 ++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared mode encoding and counter-width helper for universal_shift_reg
package usr_pkg;
    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_SHR   = 3'd3,
        MODE_ROL   = 3'd4,
        MODE_ROR   = 3'd5,
        MODE_CLEAR = 3'd6,
        MODE_RSVD  = 3'd7
    } usr_mode_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/universal_shift_reg_if.sv
// usr_if: control, data and status bundle of universal_shift_reg
interface usr_if #(parameter int WIDTH = 8);
    import usr_pkg::*;
    logic             en_i;
    usr_mode_t        mode_i;
    logic [WIDTH-1:0] d_i;
    logic             sin_l_i;
    logic             sin_r_i;
    logic [WIDTH-1:0] q_o;
    logic [WIDTH-1:0] qbar_o;
    logic             sout_l_o;
    logic             sout_r_o;
    logic             done_o;
    modport master (output en_i, mode_i, d_i, sin_l_i, sin_r_i,
                    input  q_o, qbar_o, sout_l_o, sout_r_o, done_o);
    modport slave  (input  en_i, mode_i, d_i, sin_l_i, sin_r_i,
                    output q_o, qbar_o, sout_l_o, sout_r_o, done_o);
endinterface

// File: rtl/usr_shift_counter.sv
// usr_shift_counter: counts shifts since LOAD and pulses done on the WIDTH-th
module usr_shift_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic load_i,
    input  logic shift_i,
    input  logic clear_i,
    output logic done_o
);
    localparam int CW = cnt_w(WIDTH);
    logic [CW-1:0] cnt_q;
    logic          armed_q;
    logic          done_q;
    // arm on load, count armed shifts, fire done and disarm on the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en_i) begin
                if (clear_i) begin
                    cnt_q   <= '0;
                    armed_q <= 1'b0;
                end else if (load_i) begin
                    cnt_q   <= '0;
                    armed_q <= 1'b1;
                end else if (shift_i && armed_q) begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        armed_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    end
    assign done_o = done_q;
endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: hold/load/shift/rotate/clear register; USR_ROTATE_EN enables rotates
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic clk,
    input logic rst,
    usr_if.slave bus
);
`ifdef USR_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif
    logic [WIDTH-1:0] q_q, q_d;
    logic             shift, rot;
    assign rot   = ROT_EN && (bus.mode_i == MODE_ROL || bus.mode_i == MODE_ROR);
    assign shift = bus.mode_i == MODE_SHL || bus.mode_i == MODE_SHR || rot;
    // next register value selected by mode; disabled rotates fall back to hold
    always_comb begin
        q_d = q_q;
        case (bus.mode_i)
            MODE_LOAD:  q_d = bus.d_i;
            MODE_SHL:   q_d = {q_q[WIDTH-2:0], bus.sin_l_i};
            MODE_SHR:   q_d = {bus.sin_r_i, q_q[WIDTH-1:1]};
            MODE_ROL:   q_d = rot ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} : q_q;
            MODE_ROR:   q_d = rot ? {q_q[0], q_q[WIDTH-1:1]} : q_q;
            MODE_CLEAR: q_d = '0;
            default:    q_d = q_q;
        endcase
    end
    // data register with clock enable
    always_ff @(posedge clk) begin
        if (rst) q_q <= RESET_VAL;
        else if (bus.en_i) q_q <= q_d;
    end
    usr_shift_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.en_i),
        .load_i  (bus.mode_i == MODE_LOAD),
        .shift_i (shift),
        .clear_i (bus.mode_i == MODE_CLEAR),
        .done_o  (bus.done_o)
    );
    assign bus.q_o      = q_q;
    assign bus.qbar_o   = ~q_q;
    assign bus.sout_l_o = q_q[WIDTH-1];
    assign bus.sout_r_o = q_q[0];
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed and random checks against a word-level model
module tb_universal_shift_reg;
    import usr_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;
    logic [7:0] m_q = 8'hA5;
    int   m_shifts = 0;
    bit   m_armed = 1'b0;
    bit   m_done = 1'b0;
    bit   rot_on;

    usr_if #(.WIDTH(8)) bus ();
    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input usr_mode_t m,
                        input logic [7:0] dv, input logic sl, input logic sr);
        bit moved;
        rst = r; bus.en_i = e; bus.mode_i = m; bus.d_i = dv; bus.sin_l_i = sl; bus.sin_r_i = sr;
        @(posedge clk);
        step_no++;
        m_done = 1'b0;
        moved = 1'b0;
        if (r) begin
            m_q = 8'hA5; m_shifts = 0; m_armed = 1'b0;
        end else if (e) begin
            if (m == MODE_LOAD) begin
                m_q = dv; m_armed = 1'b1; m_shifts = 0;
            end else if (m == MODE_CLEAR) begin
                m_q = 8'h00; m_armed = 1'b0; m_shifts = 0;
            end else if (m == MODE_SHL) begin
                m_q = 8'((m_q * 2) + sl); moved = 1'b1;
            end else if (m == MODE_SHR) begin
                m_q = 8'((m_q / 2) + (sr ? 128 : 0)); moved = 1'b1;
            end else if (rot_on && m == MODE_ROL) begin
                m_q = 8'((m_q * 2) + (m_q / 128)); moved = 1'b1;
            end else if (rot_on && m == MODE_ROR) begin
                m_q = 8'((m_q / 2) + ((m_q % 2) * 128)); moved = 1'b1;
            end
            if (moved && m_armed) begin
                m_shifts++;
                if (m_shifts == 8) begin
                    m_done = 1'b1; m_armed = 1'b0; m_shifts = 0;
                end
            end
        end
        #1;
        check("q", bus.q_o, m_q);
        check("qbar", bus.qbar_o, ~m_q);
        check("sout_l", {7'd0, bus.sout_l_o}, {7'd0, m_q[7]});
        check("sout_r", {7'd0, bus.sout_r_o}, {7'd0, m_q[0]});
        check("done", {7'd0, bus.done_o}, {7'd0, m_done});
    endtask

    initial begin
`ifdef USR_ROTATE_EN
        rot_on = 1'b1;
`else
        rot_on = 1'b0;
`endif
        bus.en_i = 1'b1; bus.mode_i = MODE_HOLD; bus.d_i = '0; bus.sin_l_i = 1'b0; bus.sin_r_i = 1'b0;
        // reset with random mode/data
        repeat (2) step(1, 1, usr_mode_t'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom));
        check("reset_q", bus.q_o, 8'hA5);
        check("reset_qbar", bus.qbar_o, 8'h5A);
        // load then eight left shifts, done on the last
        step(0, 1, MODE_LOAD, 8'h81, 0, 0);
        repeat (8) step(0, 1, MODE_SHL, 8'h00, 0, 0);
        check("shl_final", bus.q_o, 8'h00);
        check("shl_done", {7'd0, bus.done_o}, 8'h01);
        step(0, 1, MODE_HOLD, 8'h00, 0, 0);
        // partial right shift aborted by reset
        step(0, 1, MODE_LOAD, 8'h0F, 0, 0);
        repeat (3) step(0, 1, MODE_SHR, 8'h00, 0, 1);
        check("shr_e1", bus.q_o, 8'hE1);
        step(1, 1, MODE_SHR, 8'h00, 0, 1);
        check("rst_abort", bus.q_o, 8'hA5);
        repeat (6) step(0, 1, MODE_HOLD, 8'h00, 0, 0);
        // rotate right a full word
        step(0, 1, MODE_LOAD, 8'h96, 0, 0);
        repeat (8) step(0, 1, MODE_ROR, 8'h00, 0, 0);
        check("ror_back", bus.q_o, 8'h96);
        check("ror_done", {7'd0, bus.done_o}, {7'd0, rot_on});
        step(0, 1, MODE_LOAD, 8'h3C, 0, 0);
        repeat (8) step(0, 1, MODE_ROL, 8'h00, 0, 0);
        // clock-enable gap in the middle of a count
        step(0, 1, MODE_LOAD, 8'hFF, 0, 0);
        step(0, 1, MODE_SHL, 8'h00, 0, 0);
        repeat (5) step(0, 0, MODE_SHL, 8'h00, 0, 0);
        check("en_hold", bus.q_o, 8'hFE);
        repeat (7) step(0, 1, MODE_SHL, 8'h00, 0, 0);
        check("en_done", {7'd0, bus.done_o}, 8'h01);
        // load in the done cycle re-arms immediately
        step(0, 1, MODE_LOAD, 8'h5A, 0, 0);
        repeat (8) step(0, 1, MODE_SHR, 8'h00, 0, 1);
        // clear mid-count: no done afterwards
        step(0, 1, MODE_LOAD, 8'hC3, 0, 0);
        repeat (3) step(0, 1, MODE_SHL, 8'h00, 1, 0);
        step(0, 1, MODE_CLEAR, 8'h00, 0, 0);
        check("clear", bus.q_o, 8'h00);
        repeat (8) step(0, 1, MODE_SHL, 8'h00, 1, 0);
        // shifts after done without a new load, then reserved code
        step(0, 1, MODE_LOAD, 8'h01, 0, 0);
        repeat (8) step(0, 1, MODE_SHL, 8'h00, 1, 0);
        repeat (10) step(0, 1, MODE_SHL, 8'h00, 0, 0);
        step(0, 1, MODE_LOAD, 8'h77, 0, 0);
        step(0, 1, MODE_RSVD, 8'h00, 0, 0);
        check("rsvd", bus.q_o, 8'h77);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                 usr_mode_t'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
